spi_reg_slave: RTL and testbench

- SPI responder that terminates master command frames in a small writable/readable register file. Replaces the plain data slave when the master must configure and read back registers.
- Samples `sclk`, `cs` and `mosi` in the system clock domain and decodes fixed 12-bit command frames. Returns echo or read data on `miso` during the following frame.
- Timing matches the team's SPI convention: data driven on `sclk` rising edge, sampled on `sclk` falling edge, MSB first, `cs` active-low, `sclk` idle low.

---
 rtl/spi_reg_slave.sv | 178 +++++++++++++++++
 tb/tb_spi_reg_slave.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// SPI responder that terminates fixed-length command frames in a small register file.
// A frame is {wr_nrd, addr, data}, MSB first. The slave answers during the next frame with
// {rd_flag, addr, data}: the write echo, or the register value captured when a read committed.
// sclk, cs and mosi are sampled in the clk domain, so clk must run at least 8x sclk.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   sclk, cs, mosi       SPI inputs (cs active-low, sclk idle low)
//   miso                 registered serial response, 0 whenever no frame is active
//   regs_flat            all registers, reg[i] at [i*DATA_W +: DATA_W]
//   wr_strobe            one-cycle pulse on a committed write
//   wr_addr, wr_data     address/data of the last committed write
//   frame_done           one-cycle pulse when a complete frame commits
//   frame_err            one-cycle pulse when a frame ends with the wrong bit count
module spi_reg_slave #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sclk,
    input  logic                             cs,
    input  logic                             mosi,
    output logic                             miso,
    output logic [(2**ADDR_W)*DATA_W-1:0]    regs_flat,
    output logic                             wr_strobe,
    output logic [ADDR_W-1:0]                wr_addr,
    output logic [DATA_W-1:0]                wr_data,
    output logic                             frame_done,
    output logic                             frame_err
);

    localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned NREGS   = 2**ADDR_W;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nxt;

    logic sclk_s1, sclk_s2, sclk_d;
    logic cs_s1, cs_s2, cs_d;
    logic mosi_s1, mosi_sync;

    logic [FRAME_W-1:0] tx_buf;
    logic [FRAME_W-1:0] tx_sh;
    logic [FRAME_W-1:0] rx_sh;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  regs [NREGS];

    logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
    logic start_c, shift_tx_c, shift_rx_c, end_c, commit_c, err_c;
    logic               rx_wr_c;
    logic [ADDR_W-1:0]  rx_addr_c;
    logic [DATA_W-1:0]  rx_data_c;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_d    <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_d      <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_d    <= sclk_s2;
            cs_s1     <= cs;
            cs_s2     <= cs_s1;
            cs_d      <= cs_s2;
            mosi_s1   <= mosi;
            mosi_sync <= mosi_s1;
        end
    end

    assign sclk_rise_c =  sclk_s2 & ~sclk_d;
    assign sclk_fall_c = ~sclk_s2 &  sclk_d;
    assign cs_rise_c   =  cs_s2   & ~cs_d;
    assign cs_fall_c   = ~cs_s2   &  cs_d;

    assign rx_wr_c   = rx_sh[FRAME_W-1];
    assign rx_addr_c = rx_sh[DATA_W +: ADDR_W];
    assign rx_data_c = rx_sh[DATA_W-1:0];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and datapath controls; cs rise outranks any sclk edge in the same cycle.
    always_comb begin
        state_nxt  = state;
        start_c    = 1'b0;
        shift_tx_c = 1'b0;
        shift_rx_c = 1'b0;
        end_c      = 1'b0;
        commit_c   = 1'b0;
        err_c      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall_c) begin
                    start_c   = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise_c) begin
                    end_c     = 1'b1;
                    state_nxt = IDLE;
                    if (bit_cnt == CNT_W'(FRAME_W)) commit_c = 1'b1;
                    else                           err_c    = 1'b1;
                end else begin
                    shift_tx_c = sclk_rise_c;
                    shift_rx_c = sclk_fall_c;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift registers, register file and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs       <= '{default: '0};
            tx_buf     <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            bit_cnt    <= '0;
            miso       <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_strobe  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (start_c) begin
                tx_sh   <= tx_buf;
                rx_sh   <= '0;
                bit_cnt <= '0;
            end
            if (shift_tx_c) begin
                miso  <= tx_sh[FRAME_W-1];
                tx_sh <= {tx_sh[FRAME_W-2:0], 1'b0};
            end
            if (shift_rx_c) begin
                rx_sh <= {rx_sh[FRAME_W-2:0], mosi_sync};
                if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (end_c) miso <= 1'b0;
            if (commit_c) begin
                frame_done <= 1'b1;
                if (rx_wr_c) begin
                    regs[rx_addr_c] <= rx_data_c;
                    wr_addr         <= rx_addr_c;
                    wr_data         <= rx_data_c;
                    wr_strobe       <= 1'b1;
                    tx_buf          <= {1'b0, rx_addr_c, rx_data_c};
                end else begin
                    tx_buf          <= {1'b1, rx_addr_c, regs[rx_addr_c]};
                end
            end
            if (err_c) frame_err <= 1'b1;
        end
    end

    // Flatten the register file onto the output bus.
    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: a table of SPI frames with hand-computed responses,
// followed by directed sequences for reset mid-frame and sclk activity while deselected.
module tb_spi_reg_slave;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        miso;
    logic [63:0] regs_flat;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;
    logic        frame_err;

    spi_reg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .regs_flat  (regs_flat),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Running pulse counts; the test compares deltas across each frame.
    int         done_cnt   = 0;
    int         err_cnt    = 0;
    int         strobe_cnt = 0;
    logic [2:0] st_addr    = '0;
    logic [7:0] st_data    = '0;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
        if (wr_strobe) begin
            strobe_cnt++;
            st_addr = wr_addr;
            st_data = wr_data;
        end
    end

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic [15:0] exp_miso;
        int          exp_done;
        int          exp_err;
        int          exp_strobe;
        logic [2:0]  exp_wr_addr;
        logic [7:0]  exp_wr_data;
        logic [63:0] exp_regs;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clock out nbits of word MSB first; master drives on sclk rise and samples miso before the fall.
    task automatic send_bits(input logic [15:0] word, input int nbits, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = word[4'(nbits - 1 - i)];
            sclk = 1'b1;
            clks(8);
            rx   = {rx[14:0], miso};
            sclk = 1'b0;
            clks(8);
        end
    endtask

    task automatic xfer(input logic [15:0] word, input int nbits, output logic [15:0] rx);
        cs = 1'b0;
        clks(8);
        send_bits(word, nbits, rx);
        cs   = 1'b1;
        mosi = 1'b0;
        clks(8);
    endtask

    initial begin
        logic [15:0] rx;
        int          d0, e0, s0;
        logic        miso_seen;

        localparam logic [63:0] R1 = 64'h0000_0000_A500_0000;
        localparam logic [63:0] R2 = 64'h0000_3C00_A500_0000;
        localparam logic [63:0] R3 = 64'h0100_3C00_A500_0000;

        vecs[0] = '{16'h0BA5, 12, 16'h0000, 1, 0, 1, 3'd3, 8'hA5, R1};
        vecs[1] = '{16'h0300, 12, 16'h03A5, 1, 0, 0, 3'd3, 8'hA5, R1};
        vecs[2] = '{16'h0000, 12, 16'h0BA5, 1, 0, 0, 3'd3, 8'hA5, R1};
        vecs[3] = '{16'h00FF,  8, 16'h0080, 0, 1, 0, 3'd3, 8'hA5, R1};
        vecs[4] = '{16'h1E24, 13, 16'h1000, 0, 1, 0, 3'd3, 8'hA5, R1};
        vecs[5] = '{16'h0D3C, 12, 16'h0800, 1, 0, 1, 3'd5, 8'h3C, R2};
        vecs[6] = '{16'h05FF, 12, 16'h053C, 1, 0, 0, 3'd5, 8'h3C, R2};
        vecs[7] = '{16'h0F01, 12, 16'h0D3C, 1, 0, 1, 3'd7, 8'h01, R3};

        rst  = 1'b1;
        sclk = 1'b0;
        cs   = 1'b1;
        mosi = 1'b0;
        clks(3);
        rst = 1'b0;
        clks(2);
        check("reset miso",       64'(miso),       64'd0);
        check("reset regs",       regs_flat,       64'd0);
        check("reset wr_addr",    64'(wr_addr),    64'd0);
        check("reset wr_data",    64'(wr_data),    64'd0);
        check("reset pulses",     64'({wr_strobe, frame_done, frame_err}), 64'd0);

        for (int v = 0; v < 8; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            s0 = strobe_cnt;
            xfer(vecs[v].frame, vecs[v].nbits, rx);
            check($sformatf("vec%0d miso", v),       64'(rx),              64'(vecs[v].exp_miso));
            check($sformatf("vec%0d frame_done", v), 64'(done_cnt - d0),   64'(vecs[v].exp_done));
            check($sformatf("vec%0d frame_err", v),  64'(err_cnt - e0),    64'(vecs[v].exp_err));
            check($sformatf("vec%0d wr_strobe", v),  64'(strobe_cnt - s0), 64'(vecs[v].exp_strobe));
            if (vecs[v].exp_strobe != 0) begin
                check($sformatf("vec%0d strobe addr", v), 64'(st_addr), 64'(vecs[v].exp_wr_addr));
                check($sformatf("vec%0d strobe data", v), 64'(st_data), 64'(vecs[v].exp_wr_data));
            end
            check($sformatf("vec%0d wr_addr", v), 64'(wr_addr), 64'(vecs[v].exp_wr_addr));
            check($sformatf("vec%0d wr_data", v), 64'(wr_data), 64'(vecs[v].exp_wr_data));
            check($sformatf("vec%0d regs", v),    regs_flat,    vecs[v].exp_regs);
            check($sformatf("vec%0d idle miso", v), 64'(miso),  64'd0);
        end

        // Reset after 6 bits of 0x9FF with cs held low; the tail becomes a short frame.
        d0 = done_cnt;
        e0 = err_cnt;
        s0 = strobe_cnt;
        cs = 1'b0;
        clks(8);
        send_bits(16'h0027, 6, rx);
        check("pre-reset partial miso", 64'(rx), 64'h1C);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        clks(1);
        check("midreset miso",    64'(miso),    64'd0);
        check("midreset regs",    regs_flat,    64'd0);
        check("midreset wr_addr", 64'(wr_addr), 64'd0);
        check("midreset wr_data", 64'(wr_data), 64'd0);
        clks(8);
        send_bits(16'h003F, 6, rx);
        check("post-reset tail miso", 64'(rx), 64'd0);
        cs   = 1'b1;
        mosi = 1'b0;
        clks(8);
        check("midreset frame_err",  64'(err_cnt - e0),    64'd1);
        check("midreset frame_done", 64'(done_cnt - d0),   64'd0);
        check("midreset wr_strobe",  64'(strobe_cnt - s0), 64'd0);
        check("midreset regs after", regs_flat,            64'd0);

        // sclk toggling while deselected must be ignored.
        d0 = done_cnt;
        e0 = err_cnt;
        s0 = strobe_cnt;
        miso_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mosi = i[0];
            sclk = 1'b1;
            clks(8);
            miso_seen |= miso;
            sclk = 1'b0;
            clks(8);
            miso_seen |= miso;
        end
        mosi = 1'b0;
        check("cs high miso",    64'(miso_seen),                                   64'd0);
        check("cs high pulses",  64'((done_cnt - d0) + (err_cnt - e0) + (strobe_cnt - s0)), 64'd0);
        check("cs high bit_cnt", 64'(dut.bit_cnt),                                 64'd6);

        // Recovery: a normal write after the error frame still answers with the cleared tx_buf.
        d0 = done_cnt;
        s0 = strobe_cnt;
        xfer(16'h095A, 12, rx);
        check("recover miso",      64'(rx),              64'd0);
        check("recover done",      64'(done_cnt - d0),   64'd1);
        check("recover wr_strobe", 64'(strobe_cnt - s0), 64'd1);
        check("recover wr_addr",   64'(wr_addr),         64'd1);
        check("recover wr_data",   64'(wr_data),         64'h5A);
        check("recover regs",      regs_flat,            64'h0000_0000_0000_5A00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
